// File: rtl/mem_access_unit.sv
// Initiator side of the word-addressed data memory: byte/half/word loads and stores,
// sub-word stores done as read-modify-write, with a done/err completion handshake.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_op,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wd,
    input  logic [31:0]       i_mem_rd
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMerge,
        StStore,
        StResp
    } state_e;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;
    localparam logic [1:0] SzBad  = 2'b11;

    state_e            r_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [15:0]       r_wdata;
    logic [31:0]       r_merge;
    logic              r_err;
    logic [31:0]       r_rdata;

    state_e            w_state_nxt;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [1:0]        w_off_nxt;
    logic [1:0]        w_size_nxt;
    logic              w_uns_nxt;
    logic [15:0]       w_wdata_nxt;
    logic [31:0]       w_merge_nxt;
    logic              w_err_nxt;
    logic [31:0]       w_rdata_nxt;

    logic              w_bad;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;
    logic              w_unused_addr;

    // Byte-address bits above the word-address field do not reach the memory.
    assign w_unused_addr = ^i_addr[31:ADDR_W+2];

    // Request decode in IDLE: misaligned half/word or the reserved size is an error.
    always_comb begin
        w_bad = 1'b0;
        unique case (i_op[1:0])
            SzByte: w_bad = 1'b0;
            SzHalf: w_bad = i_addr[0];
            SzWord: w_bad = (i_addr[1:0] != 2'b00);
            SzBad:  w_bad = 1'b1;
            default: w_bad = 1'b1;
        endcase
    end

    // Little-endian lane selection and extension of the load result.
    always_comb begin
        w_byte = 8'h00;
        unique case (r_off)
            2'd0: w_byte = i_mem_rd[7:0];
            2'd1: w_byte = i_mem_rd[15:8];
            2'd2: w_byte = i_mem_rd[23:16];
            2'd3: w_byte = i_mem_rd[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_off[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
        unique case (r_size)
            SzByte: w_load = {{24{w_byte[7] & ~r_uns}}, w_byte};
            SzHalf: w_load = {{16{w_half[15] & ~r_uns}}, w_half};
            default: w_load = i_mem_rd;
        endcase
    end

    // Replace the addressed lane of the current memory word with the store data.
    always_comb begin
        w_merged = i_mem_rd;
        if (r_size == SzByte) begin
            w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_waddr_nxt = r_waddr;
        w_off_nxt   = r_off;
        w_size_nxt  = r_size;
        w_uns_nxt   = r_uns;
        w_wdata_nxt = r_wdata;
        w_merge_nxt = r_merge;
        w_err_nxt   = r_err;
        w_rdata_nxt = r_rdata;
        unique case (r_state)
            StIdle: begin
                if (i_req) begin
                    w_waddr_nxt = i_addr[ADDR_W+1:2];
                    w_off_nxt   = i_addr[1:0];
                    w_size_nxt  = i_op[1:0];
                    w_uns_nxt   = i_op[2];
                    w_wdata_nxt = i_wdata[15:0];
                    w_err_nxt   = w_bad;
                    if (w_bad) begin
                        w_state_nxt = StResp;
                    end else if (!i_we) begin
                        w_state_nxt = StLoad;
                    end else if (i_op[1:0] == SzWord) begin
                        w_merge_nxt = i_wdata;
                        w_state_nxt = StStore;
                    end else begin
                        w_state_nxt = StMerge;
                    end
                end
            end
            StLoad: begin
                w_rdata_nxt = w_load;
                w_state_nxt = StResp;
            end
            StMerge: begin
                w_merge_nxt = w_merged;
                w_state_nxt = StStore;
            end
            StStore: w_state_nxt = StResp;
            StResp:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_waddr <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_merge <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_waddr <= w_waddr_nxt;
            r_off   <= w_off_nxt;
            r_size  <= w_size_nxt;
            r_uns   <= w_uns_nxt;
            r_wdata <= w_wdata_nxt;
            r_merge <= w_merge_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    // Reset gates the write strobe so an op aborted in STORE never commits.
    assign o_mem_we   = (r_state == StStore) && !i_reset;
    assign o_mem_addr = r_waddr;
    assign o_mem_wd   = r_merge;
    assign o_busy     = (r_state != StIdle);
    assign o_done     = (r_state == StResp);
    assign o_err      = (r_state == StResp) && r_err;
    assign o_rdata    = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a reference word memory predicts load data,
// merged store words, err, busy-cycle latency and write-strobe count for every request.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned Depth  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              we;
    logic [2:0]        op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    typedef struct {
        logic [31:0]       rdata;
        logic              err;
        int                lat;
        int                nwe;
        logic [ADDR_W-1:0] waddr;
        logic [31:0]       wd;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          done_total = 0;
    int          we_total   = 0;
    int          cyc        = 0;
    int          we_cnt     = 0;
    logic [31:0] exp_rdata;

    bit [31:0] mem [Depth];
    bit        mem_wr [Depth];
    bit [31:0] ref_mem [Depth];
    bit        ref_wr [Depth];

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req      (req),
        .i_we       (we),
        .i_op       (op),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_rdata    (rdata),
        .o_done     (done),
        .o_err      (err),
        .o_busy     (busy),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_wd   (mem_wd),
        .i_mem_rd   (mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
        return 32'hA5C3_0000 ^ {a, 4'h0, a[7:0], a[7:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]    <= mem_wd;
            mem_wr[mem_addr] <= 1'b1;
        end
    end

    always_comb mem_rd = mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: counts busy cycles and write strobes per op, scores each done pulse.
    always @(negedge clk) begin
        if (mem_we) we_total++;
        if (reset) begin
            cyc    = 0;
            we_cnt = 0;
        end else begin
            if (busy) cyc++;
            if (mem_we) begin
                we_cnt++;
                if (sb_q.size() > 0) begin
                    check("we_addr", 32'(mem_addr), 32'(sb_q[0].waddr));
                    check("we_data", mem_wd, sb_q[0].wd);
                end
            end
            if (done) begin
                done_total++;
                check("sb_nonempty", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("rdata", rdata, mon_e.rdata);
                    check("err", 32'(err), 32'(mon_e.err));
                    check("latency", cyc, mon_e.lat);
                    check("we_count", we_cnt, mon_e.nwe);
                end
                cyc    = 0;
                we_cnt = 0;
            end
        end
    end

    task automatic push_exp(input logic w, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] d);
        exp_t              e;
        logic [ADDR_W-1:0] wa;
        logic [1:0]        off;
        logic [31:0]       word;
        logic [31:0]       sh;
        logic [31:0]       mask;
        bit                bad;
        wa   = a[ADDR_W+1:2];
        off  = a[1:0];
        word = ref_wr[wa] ? ref_mem[wa] : init_val(wa);
        bad  = (o[1:0] == 2'b11) || (o[1:0] == 2'b01 && off[0]) ||
               (o[1:0] == 2'b10 && off != 2'b00);
        e.err   = bad;
        e.waddr = wa;
        e.wd    = 32'h0;
        e.nwe   = 0;
        if (bad) begin
            e.lat = 1;
        end else if (!w) begin
            e.lat = 2;
            sh = word >> (8 * off);
            case (o[1:0])
                2'b00:   exp_rdata = o[2] ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
                2'b01:   exp_rdata = o[2] ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
                default: exp_rdata = word;
            endcase
        end else begin
            e.nwe = 1;
            e.lat = (o[1:0] == 2'b10) ? 2 : 3;
            mask  = (o[1:0] == 2'b00) ? 32'hFF : (o[1:0] == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
            mask  = mask << (8 * off);
            e.wd  = (word & ~mask) | ((d << (8 * off)) & mask);
            ref_mem[wa] = e.wd;
            ref_wr[wa]  = 1'b1;
        end
        e.rdata = exp_rdata;
        sb_q.push_back(e);
    endtask

    task automatic run_op(input logic w, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] d);
        int start;
        bit got;
        push_exp(w, o, a, d);
        @(posedge clk);
        #1;
        req   = 1'b1;
        we    = w;
        op    = o;
        addr  = a;
        wdata = d;
        start = done_total;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_total != start) got = 1'b1;
        end
        if (!got) begin
            check("timeout", 32'(done_total - start), 1);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_rdata = 32'h0;
    endtask

    initial begin
        int we_before;
        int start;
        int n;
        reset = 1'b1; req = 1'b0; we = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
        exp_rdata = 32'h0;
        do_reset();
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wd", mem_wd, 32'h0);

        run_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);   // sw
        run_op(1'b0, 3'b000, 32'h13, 32'h0);           // lb
        run_op(1'b0, 3'b100, 32'h13, 32'h0);           // lbu
        run_op(1'b0, 3'b001, 32'h10, 32'h0);           // lh
        run_op(1'b0, 3'b101, 32'h12, 32'h0);           // lhu
        run_op(1'b1, 3'b000, 32'h11, 32'h1234_5678);   // sb
        run_op(1'b0, 3'b010, 32'h10, 32'h0);           // lw
        run_op(1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF);   // misaligned sh
        run_op(1'b0, 3'b010, 32'h12, 32'h0);           // misaligned lw
        run_op(1'b0, 3'b011, 32'h10, 32'h0);           // illegal size load
        run_op(1'b1, 3'b111, 32'h10, 32'h0);           // illegal size store
        run_op(1'b1, 3'b001, 32'h12, 32'hCAFE_1234);   // sh upper half
        run_op(1'b0, 3'b001, 32'h12, 32'h0);
        run_op(1'b0, 3'b000, 32'hFFFF_C010, 32'h0);    // high address bits ignored

        // Reset while an sb sits in MERGE: nothing written, unit idle afterwards.
        we_before = we_total;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; op = 3'b000; addr = 32'h10; wdata = 32'h55;
        @(posedge clk); #1;
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        check("abort_merge_accepted", 32'(busy), 1);
        @(posedge clk); #1;
        reset = 1'b0; exp_rdata = 32'h0;
        @(negedge clk);
        check("abort_merge_busy", 32'(busy), 0);
        check("abort_merge_done", 32'(done), 0);
        check("abort_merge_rdata", rdata, 32'h0);
        check("abort_merge_we", we_total, we_before);
        run_op(1'b0, 3'b010, 32'h10, 32'h0);

        // Reset in the STORE cycle itself must suppress the write strobe.
        we_before = we_total;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; op = 3'b010; addr = 32'h10; wdata = 32'h0;
        @(posedge clk); #1;
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        check("abort_store_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        reset = 1'b0; exp_rdata = 32'h0;
        @(negedge clk);
        check("abort_store_busy", 32'(busy), 0);
        check("abort_store_count", we_total, we_before);
        run_op(1'b0, 3'b010, 32'h10, 32'h0);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom & 32'hFFFF_C03F, $urandom);
        end

        // req held across the whole op with new inputs: second op taken after RESP.
        push_exp(1'b0, 3'b010, 32'h10, 32'h0);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; op = 3'b010; addr = 32'h10;
        @(posedge clk); #1;
        push_exp(1'b0, 3'b101, 32'h8000_0012, 32'h0);
        op = 3'b101; addr = 32'h8000_0012;
        start = done_total;
        n = 0;
        for (int i = 0; i < 30 && (done_total - start) < 2; i++) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("b2b_cycles", n, 5);
        check("b2b_done_count", 32'(done_total - start), 2);
        @(posedge clk); #1;
        req = 1'b0;

        repeat (4) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data memory interface.
- Accepts byte, halfword and word load/store requests from the CPU datapath.
- Drives the memory's single-word write port, using read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data with a done/err handshake, so the pipeline stalls on busy.

Parameters:
- ADDR_W, 12: memory word-address width; mem_addr = byte address[ADDR_W+1:2]; higher byte-address bits ignored.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- op  in  3  op[1:0] size (00 byte, 01 half, 10 word, 11 illegal); op[2] unsigned load (ignored for stores)
- addr  in  32  byte address
- wdata  in  32  store data (sub-word taken from LSBs)
- rdata  out  32  extended load result, valid while done=1
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done on misaligned/illegal request
- busy  out  1  high whenever state != IDLE
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data; combinational function of mem_addr

Behaviour:
- Reset values: state IDLE; rdata, done, err, busy, mem_we, mem_addr, mem_wd all 0. Reset has priority in every state and aborts any in-flight op with no write; mem_we is forced 0 in the reset cycle.
- States: IDLE, LOAD, MERGE, STORE, RESP.
- IDLE, req=1 (accept): latch word address = addr[ADDR_W+1:2], byte offset = addr[1:0], op, we, wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11 -> RESP with err=1.
  - Else load -> LOAD; sw -> STORE with merge register = wdata; sb/sh -> MERGE.
- req while busy is ignored (not queued). The requester holds req until done.
- LOAD: mem_addr = latched word address. Select the byte/half from mem_rd using the offset, little-endian (offset 0 = bits 7:0, half offset 2 = bits 31:16). Sign-extend if op[2]=0, else zero-extend. Word passes through. Register into rdata -> RESP.
- MERGE: mem_addr = latched word address. Merge register = mem_rd with the addressed lane replaced by wdata[7:0] (byte) or wdata[15:0] (half) -> STORE.
- STORE: mem_we=1 for exactly this cycle, mem_addr = latched word address, mem_wd = merge register -> RESP.
- RESP: done=1 (plus err if flagged) -> IDLE. rdata holds its value until the next load completes; stores and errors do not change rdata.
- Latency from the accept edge to done:
  - load: 2 cycles (LOAD, RESP)
  - sw: 2 cycles (STORE, RESP)
  - sb/sh: 3 cycles (MERGE, STORE, RESP)
  - error: 1 cycle (RESP)
- Back-to-back requests: a new req is accepted in the IDLE cycle that follows RESP, giving minimum 1 idle cycle between done and the next accept edge.
- mem_we is never asserted outside STORE, and never for err requests.
- A store followed by a load to the same word returns the new data (the write commits at the STORE edge, before LOAD).

Test Plan:
- reset, then sw addr=0x10 wdata=0xDEADBEEF -> mem_we pulse once with mem_addr=4, mem_wd=0xDEADBEEF; done 2 cycles after accept; err=0.
- with memory word 4 = 0xDEADBEEF: lb addr=0x13 -> rdata=0xFFFFFFDE; lbu addr=0x13 -> 0x000000DE; lh addr=0x10 -> 0xFFFFBEEF; lhu addr=0x12 -> 0x0000DEAD; each done 2 cycles after accept.
- sb addr=0x11 wdata=0x12345678, then lw addr=0x10 -> memory word becomes 0xDEAD78EF; mem_we high only in STORE; done 3 cycles after accept.
- sh addr=0x11 and lw addr=0x12 -> done with err=1 after 1 cycle, mem_we never high, rdata unchanged; op size 11 -> err=1.
- assert reset during MERGE of an sb -> no mem_we, busy=0 and done=0 after reset; a following lw returns the old word unchanged.
- req held continuously with changing addr while busy -> only the first is accepted; the second is accepted on the IDLE cycle after RESP; total cycle count matches the latency table.
